rbcp_reg_bank: RTL and testbench

Byte-wide control/status register bank on the SiTCP RBCP (UDP slow-control) local bus, in the USRCLK domain, directly downstream of the SiTCP core's RBCP_* outputs. Decodes a 32-byte window at BASE_ADDR and commits writes to control registers. Returns read data from control, status, version and access-counter registers. Drives RBCP_ACK with a fixed two-cycle latency. Addresses outside the window get no ACK, so parallel slaves can share the bus.

---
 rtl/rbcp_reg_pkg.sv | 34 +++
 rtl/rbcp_reg_bank_if.sv | 35 +++
 rtl/rbcp_reg_bank.sv | 203 ++++++++++++++++++++
 tb/tb_rbcp_reg_bank.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbcp_reg_pkg.sv
// -----------------------------------------------------------------------------
// rbcp_reg_pkg
//   Shared definitions for the RBCP register bank: the size of the decoded
//   address window, the offsets of each register region inside it, and the
//   transaction state encoding.
// -----------------------------------------------------------------------------
package rbcp_reg_pkg;

  // The bank decodes a 32-byte window; the low address bits form the offset.
  localparam int WINDOW_SIZE = 32;
  localparam int OFS_W       = $clog2(WINDOW_SIZE);

  typedef logic [OFS_W-1:0] ofs_t;

  // Upper bounds on the two banked regions so they never overlap the
  // single-byte registers at the top of the window.
  localparam int MAX_CTRL = 16;
  localparam int MAX_STAT = 13;

  // Region and register offsets within the window.
  localparam ofs_t OFS_CTRL  = 5'h00;
  localparam ofs_t OFS_STAT  = 5'h10;
  localparam ofs_t OFS_CNT   = 5'h1D;
  localparam ofs_t OFS_VER   = 5'h1E;
  localparam ofs_t OFS_PULSE = 5'h1F;

  // One transaction walks IDLE -> ACCESS -> ACK -> IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

endpackage : rbcp_reg_pkg

// File: rtl/rbcp_reg_bank_if.sv
// -----------------------------------------------------------------------------
// rbcp_reg_bank_if
//   SiTCP RBCP local bus bundle.
//   master : the SiTCP core side (drives ACT/ADDR/WE/WD/RE, receives ACK/RD).
//   slave  : a register bank on the bus (the reverse).
//   Signals:
//     RBCP_ACT   transaction active
//     RBCP_ADDR  32-bit byte address
//     RBCP_WE    single-cycle write strobe
//     RBCP_WD    8-bit write data
//     RBCP_RE    single-cycle read strobe
//     RBCP_ACK   one-cycle access acknowledge
//     RBCP_RD    8-bit read data, valid with RBCP_ACK
// -----------------------------------------------------------------------------
interface rbcp_reg_bank_if;

  logic        RBCP_ACT;
  logic [31:0] RBCP_ADDR;
  logic        RBCP_WE;
  logic [7:0]  RBCP_WD;
  logic        RBCP_RE;
  logic        RBCP_ACK;
  logic [7:0]  RBCP_RD;

  modport master (
    output RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE,
    input  RBCP_ACK, RBCP_RD
  );

  modport slave (
    input  RBCP_ACT, RBCP_ADDR, RBCP_WE, RBCP_WD, RBCP_RE,
    output RBCP_ACK, RBCP_RD
  );

endinterface : rbcp_reg_bank_if

// File: rtl/rbcp_reg_bank.sv
// -----------------------------------------------------------------------------
// rbcp_reg_bank
//   Byte-wide control/status register bank on the SiTCP RBCP local bus.
//   Decodes a 32-byte window at BASE_ADDR and answers every in-window access
//   with a one-cycle RBCP_ACK exactly two cycles after the strobe. Accesses
//   outside the window are left alone so other slaves can share the bus.
//
//   Window map (offset = address - BASE_ADDR):
//     0x00-0x0F  control bytes, R/W (offsets >= NUM_CTRL read 0, ignore writes)
//     0x10-0x1C  status bytes, RO   (offsets >= 0x10+NUM_STAT read 0)
//     0x1D       access counter, RO (+1 per acknowledged access, wraps)
//     0x1E       VERSION, RO
//     0x1F       pulse register, write-only, reads 0
//
//   Ports:
//     USRCLK     sole clock
//     RST        asynchronous active-high reset
//     rbcp       RBCP bus, slave side
//     CTRL_OUT   control bytes, byte k at bits [8k+7:8k] = offset k
//     STATUS_IN  status bytes, byte k = offset 0x10+k, synchronous to USRCLK
//     PULSE_OUT  command bits, equal to the written byte during the ACK cycle
//
//   All outputs come straight from registers.
// -----------------------------------------------------------------------------
module rbcp_reg_bank
  import rbcp_reg_pkg::*;
#(
  parameter logic [31:0]           BASE_ADDR = 32'h0000_0000,
  parameter int                    NUM_CTRL  = 8,
  parameter int                    NUM_STAT  = 4,
  parameter logic [8*NUM_CTRL-1:0] CTRL_INIT = '0,
  parameter logic [7:0]            VERSION   = 8'h01
) (
  input  logic                    USRCLK,
  input  logic                    RST,
  rbcp_reg_bank_if.slave          rbcp,
  output logic [8*NUM_CTRL-1:0]   CTRL_OUT,
  input  logic [8*NUM_STAT-1:0]   STATUS_IN,
  output logic [7:0]              PULSE_OUT
);

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;

  ofs_t                    ofs_q;     // offset latched at the strobe
  logic [7:0]              wd_q;      // write data latched at the strobe
  logic                    wr_q;      // 1 = write, 0 = read

  logic [8*NUM_CTRL-1:0]   ctrl_q;
  logic [7:0]              cnt_q;
  logic [7:0]              rd_q;
  logic [7:0]              pulse_q;
  logic                    ack_q;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic in_window;
  logic strobe;
  logic accept;     // latch a new transaction this cycle
  logic complete;   // ACCESS finishing with ACT still high

  assign in_window = (rbcp.RBCP_ADDR[31:OFS_W] == BASE_ADDR[31:OFS_W]);
  assign strobe    = rbcp.RBCP_WE | rbcp.RBCP_RE;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge USRCLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Out-of-window strobes are not ours: no state change, no side effects.
        if (rbcp.RBCP_ACT && strobe && in_window) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Dropping ACT here aborts the transaction before anything commits.
        if (rbcp.RBCP_ACT) begin
          complete = 1'b1;
          state_d  = ACK;
        end else begin
          state_d  = IDLE;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read mux, evaluated on the latched offset during ACCESS. STATUS_IN is
  // therefore sampled on the ACCESS -> ACK edge.
  // ---------------------------------------------------------------------------
  logic [7:0] rd_sel;

  always_comb begin
    rd_sel = 8'h00;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (ofs_q == ofs_t'(int'(OFS_CTRL) + k)) begin
        rd_sel = ctrl_q[8*k +: 8];
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (ofs_q == ofs_t'(int'(OFS_STAT) + k)) begin
        rd_sel = STATUS_IN[8*k +: 8];
      end
    end
    if (ofs_q == OFS_CNT) begin
      rd_sel = cnt_q;
    end
    if (ofs_q == OFS_VER) begin
      rd_sel = VERSION;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge USRCLK or posedge RST) begin
    // NOTE: every register here is reset, including the transaction latches,
    // so a reset mid-transaction leaves no stale offset or data behind.
    if (RST) begin
      ofs_q   <= '0;
      wd_q    <= '0;
      wr_q    <= 1'b0;
      ctrl_q  <= CTRL_INIT;
      cnt_q   <= '0;
      rd_q    <= '0;
      pulse_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      if (accept) begin
        ofs_q <= rbcp.RBCP_ADDR[OFS_W-1:0];
        wd_q  <= rbcp.RBCP_WD;
        // A simultaneous WE and RE is handled as a write.
        wr_q  <= rbcp.RBCP_WE;
      end

      // ACK, RD and PULSE are all live only for the single ACK cycle.
      ack_q <= complete;

      if (complete) begin
        if (wr_q) begin
          for (int k = 0; k < NUM_CTRL; k++) begin
            if (ofs_q == ofs_t'(int'(OFS_CTRL) + k)) begin
              ctrl_q[8*k +: 8] <= wd_q;
            end
          end
          pulse_q <= (ofs_q == OFS_PULSE) ? wd_q : 8'h00;
          rd_q    <= 8'h00;
        end else begin
          pulse_q <= 8'h00;
          rd_q    <= rd_sel;
        end
      end else begin
        pulse_q <= 8'h00;
        rd_q    <= 8'h00;
      end

      // Counting on the ACK exit edge means a read of the counter returns the
      // count before its own access.
      if (state_q == ACK) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rbcp.RBCP_ACK = ack_q;
  assign rbcp.RBCP_RD  = rd_q;
  assign CTRL_OUT      = ctrl_q;
  assign PULSE_OUT     = pulse_q;

endmodule : rbcp_reg_bank

// File: tb/tb_rbcp_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_rbcp_reg_bank
//   Self-checking bench for rbcp_reg_bank. A byte-array model of the window
//   (control bytes, status from the driven STATUS_IN, an acknowledged-access
//   tally) supplies every expected value. Inputs change and outputs are
//   sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_rbcp_reg_bank;

  localparam logic [31:0] BASE = 32'h1234_5600;
  localparam int          NC   = 8;
  localparam int          NS   = 4;
  localparam logic [63:0] INIT = 64'h8877_6655_4433_2211;
  localparam logic [7:0]  VER  = 8'h01;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ctrl_out;
  logic [31:0] status_in;
  logic [7:0]  pulse_out;

  always #4 clk = ~clk;

  rbcp_reg_bank_if bus ();

  rbcp_reg_bank #(
    .BASE_ADDR (BASE),
    .NUM_CTRL  (NC),
    .NUM_STAT  (NS),
    .CTRL_INIT (INIT),
    .VERSION   (VER)
  ) dut (
    .USRCLK    (clk),
    .RST       (rst),
    .rbcp      (bus),
    .CTRL_OUT  (ctrl_out),
    .STATUS_IN (status_in),
    .PULSE_OUT (pulse_out)
  );

  int checks = 0;
  int passes = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0]  ctrl_m [16];
  int          acks_m;
  logic [63:0] init_v;

  task automatic model_reset();
    init_v = INIT;
    for (int k = 0; k < 16; k++) ctrl_m[k] = (k < NC) ? init_v[8*k +: 8] : 8'h00;
    acks_m = 0;
  endtask

  function automatic logic [7:0] exp_read(input int ofs);
    if (ofs < NC)                  return ctrl_m[ofs];
    if (ofs >= 16 && ofs < 16 + NS) return status_in[8*(ofs-16) +: 8];
    if (ofs == 29)                 return 8'(acks_m % 256);
    if (ofs == 30)                 return VER;
    return 8'h00;
  endfunction

  function automatic logic [63:0] exp_ctrl();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < NC; k++) v[8*k +: 8] = ctrl_m[k];
    return v;
  endfunction

  task automatic model_commit(input int ofs, input logic we, input logic [7:0] wd);
    if (we && ofs < NC) ctrl_m[ofs] = wd;
    acks_m++;
  endtask

  // ---------------------------------------------------------------------------
  // One complete transaction. Observations from cycles 1, 2 and 3 after the
  // strobe cycle are returned for the caller to judge.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  ack;       // {cycle1, cycle2, cycle3}
    logic [7:0]  rd;        // cycle 2
    logic [7:0]  rd_after;  // cycle 3
    logic [7:0]  pulse1;
    logic [7:0]  pulse2;
    logic [7:0]  pulse3;
    logic [63:0] ctrl1;
    logic [63:0] ctrl2;
  } obs_t;

  task automatic xact(input logic [31:0] addr, input logic we, input logic re,
                      input logic [7:0] wd, output obs_t o);
    @(negedge clk);
    bus.RBCP_ACT  = 1'b1;
    bus.RBCP_ADDR = addr;
    bus.RBCP_WE   = we;
    bus.RBCP_RE   = re;
    bus.RBCP_WD   = wd;
    @(negedge clk);
    bus.RBCP_WE = 1'b0;
    bus.RBCP_RE = 1'b0;
    o.ack[2] = bus.RBCP_ACK;
    o.pulse1 = pulse_out;
    o.ctrl1  = ctrl_out;
    @(negedge clk);
    o.ack[1] = bus.RBCP_ACK;
    o.rd     = bus.RBCP_RD;
    o.pulse2 = pulse_out;
    o.ctrl2  = ctrl_out;
    @(negedge clk);
    bus.RBCP_ACT = 1'b0;
    o.ack[0]   = bus.RBCP_ACK;
    o.rd_after = bus.RBCP_RD;
    o.pulse3   = pulse_out;
  endtask

  task automatic bus_idle();
    bus.RBCP_ACT  = 1'b0;
    bus.RBCP_ADDR = 32'h0;
    bus.RBCP_WE   = 1'b0;
    bus.RBCP_RE   = 1'b0;
    bus.RBCP_WD   = 8'h00;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    status_in = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.RBCP_ACK !== 1'b0) $display("FAIL reset_ack: got %b want 0", bus.RBCP_ACK); else passes++;
    checks++; if (bus.RBCP_RD !== 8'h00) $display("FAIL reset_rd: got %h want 00", bus.RBCP_RD); else passes++;
    checks++; if (pulse_out !== 8'h00) $display("FAIL reset_pulse: got %h want 00", pulse_out); else passes++;
    checks++; if (ctrl_out !== INIT) $display("FAIL reset_ctrl: got %h want %h", ctrl_out, INIT); else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ctrl_out !== exp_ctrl()) $display("FAIL reset_ctrl_after: got %h want %h", ctrl_out, exp_ctrl()); else passes++;
  endtask

  task automatic test_write_read_ctrl();
    obs_t o;
    xact(BASE + 32'h03, 1'b1, 1'b0, 8'hA5, o);
    checks++; if (o.ack !== 3'b010) $display("FAIL wr_ack_timing: got %b want 010", o.ack); else passes++;
    checks++; if (o.ctrl1[31:24] !== ctrl_m[3]) $display("FAIL wr_ctrl_cycle1: got %h want %h", o.ctrl1[31:24], ctrl_m[3]); else passes++;
    model_commit(3, 1'b1, 8'hA5);
    checks++; if (o.ctrl2 !== exp_ctrl()) $display("FAIL wr_ctrl_cycle2: got %h want %h", o.ctrl2, exp_ctrl()); else passes++;
    checks++; if (o.rd !== 8'h00) $display("FAIL wr_rd_zero: got %h want 00", o.rd); else passes++;
    xact(BASE + 32'h03, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.ack !== 3'b010) $display("FAIL rd_ack_timing: got %b want 010", o.ack); else passes++;
    checks++; if (o.rd !== 8'hA5) $display("FAIL rd_ctrl3: got %h want a5", o.rd); else passes++;
    checks++; if (o.rd_after !== 8'h00) $display("FAIL rd_after_ack: got %h want 00", o.rd_after); else passes++;
    model_commit(3, 1'b0, 8'h00);
  endtask

  task automatic test_status_version();
    obs_t o;
    logic [7:0] exp;
    status_in = 32'hD4C3_3CE1;
    xact(BASE + 32'h11, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h3C) $display("FAIL rd_status1: got %h want 3c", o.rd); else passes++;
    model_commit(17, 1'b0, 8'h00);
    xact(BASE + 32'h1E, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h01) $display("FAIL rd_version: got %h want 01", o.rd); else passes++;
    model_commit(30, 1'b0, 8'h00);
    xact(BASE + 32'h1F, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h00) $display("FAIL rd_pulse_reg: got %h want 00", o.rd); else passes++;
    model_commit(31, 1'b0, 8'h00);
    xact(BASE + 32'h11, 1'b1, 1'b0, 8'hFF, o);
    checks++; if (o.ack !== 3'b010) $display("FAIL wr_status_ack: got %b want 010", o.ack); else passes++;
    model_commit(17, 1'b1, 8'hFF);
    checks++; if (o.ctrl2 !== exp_ctrl()) $display("FAIL wr_status_ctrl: got %h want %h", o.ctrl2, exp_ctrl()); else passes++;
    xact(BASE + 32'h11, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h3C) $display("FAIL rd_status1_again: got %h want 3c", o.rd); else passes++;
    model_commit(17, 1'b0, 8'h00);
    xact(BASE + 32'h14, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h00) $display("FAIL rd_status_beyond: got %h want 00", o.rd); else passes++;
    model_commit(20, 1'b0, 8'h00);
    xact(BASE + 32'h0A, 1'b1, 1'b0, 8'h99, o);
    model_commit(10, 1'b1, 8'h99);
    checks++; if (o.ack !== 3'b010 || o.ctrl2 !== exp_ctrl()) $display("FAIL wr_ctrl_beyond: ack %b ctrl %h want 010 %h", o.ack, o.ctrl2, exp_ctrl()); else passes++;
    exp = exp_read(10);
    xact(BASE + 32'h0A, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== exp) $display("FAIL rd_ctrl_beyond: got %h want %h", o.rd, exp); else passes++;
    model_commit(10, 1'b0, 8'h00);
  endtask

  task automatic test_pulse();
    obs_t o;
    xact(BASE + 32'h1F, 1'b1, 1'b0, 8'h81, o);
    checks++; if (o.ack !== 3'b010) $display("FAIL pulse_ack: got %b want 010", o.ack); else passes++;
    checks++; if ({o.pulse1, o.pulse2, o.pulse3} !== {8'h00, 8'h81, 8'h00})
      $display("FAIL pulse_shape: got %h/%h/%h want 00/81/00", o.pulse1, o.pulse2, o.pulse3); else passes++;
    model_commit(31, 1'b1, 8'h81);
  endtask

  task automatic test_out_of_window();
    logic [31:0] addrs [3];
    logic        wes   [3];
    obs_t        o;
    logic [7:0]  exp;
    int          acks;
    int          rd_nz;
    addrs[0] = BASE + 32'h20; wes[0] = 1'b0;
    addrs[1] = BASE - 32'h01; wes[1] = 1'b0;
    addrs[2] = BASE + 32'h23; wes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      acks  = 0;
      rd_nz = 0;
      @(negedge clk);
      bus.RBCP_ACT  = 1'b1;
      bus.RBCP_ADDR = addrs[i];
      bus.RBCP_WE   = wes[i];
      bus.RBCP_RE   = ~wes[i];
      bus.RBCP_WD   = 8'h5A;
      @(negedge clk);
      bus.RBCP_WE = 1'b0;
      bus.RBCP_RE = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (bus.RBCP_ACK === 1'b1) acks++;
        if (bus.RBCP_RD !== 8'h00) rd_nz++;
        @(negedge clk);
      end
      bus.RBCP_ACT = 1'b0;
      checks++; if (acks !== 0 || rd_nz !== 0) $display("FAIL oow_%0d: acks %0d nonzero_rd %0d want 0 0", i, acks, rd_nz); else passes++;
      checks++; if (ctrl_out !== exp_ctrl()) $display("FAIL oow_ctrl_%0d: got %h want %h", i, ctrl_out, exp_ctrl()); else passes++;
    end
    exp = exp_read(29);
    xact(BASE + 32'h1D, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== exp) $display("FAIL oow_counter: got %h want %h", o.rd, exp); else passes++;
    model_commit(29, 1'b0, 8'h00);
  endtask

  task automatic test_strobe_in_access();
    int acks;
    acks = 0;
    @(negedge clk);
    bus.RBCP_ACT  = 1'b1;
    bus.RBCP_ADDR = BASE + 32'h04;
    bus.RBCP_WE   = 1'b1;
    bus.RBCP_WD   = 8'h12;
    @(negedge clk);
    if (bus.RBCP_ACK === 1'b1) acks++;
    bus.RBCP_ADDR = BASE + 32'h05;
    bus.RBCP_WD   = 8'h34;
    @(negedge clk);
    bus.RBCP_WE = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (bus.RBCP_ACK === 1'b1) acks++;
      @(negedge clk);
    end
    bus.RBCP_ACT = 1'b0;
    model_commit(4, 1'b1, 8'h12);
    checks++; if (acks !== 1) $display("FAIL ignored_strobe_acks: got %0d want 1", acks); else passes++;
    checks++; if (ctrl_out !== exp_ctrl()) $display("FAIL ignored_strobe_ctrl: got %h want %h", ctrl_out, exp_ctrl()); else passes++;
  endtask

  task automatic test_abort();
    obs_t       o;
    logic [7:0] exp;
    int         acks;
    acks = 0;
    @(negedge clk);
    bus.RBCP_ACT  = 1'b1;
    bus.RBCP_ADDR = BASE;
    bus.RBCP_WE   = 1'b1;
    bus.RBCP_WD   = 8'h55;
    @(negedge clk);
    bus.RBCP_WE  = 1'b0;
    bus.RBCP_ACT = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (bus.RBCP_ACK === 1'b1 || pulse_out !== 8'h00) acks++;
      @(negedge clk);
    end
    checks++; if (acks !== 0) $display("FAIL abort_ack: got %0d want 0", acks); else passes++;
    checks++; if (ctrl_out[7:0] !== ctrl_m[0]) $display("FAIL abort_ctrl0: got %h want %h", ctrl_out[7:0], ctrl_m[0]); else passes++;
    exp = exp_read(29);
    xact(BASE + 32'h1D, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== exp) $display("FAIL abort_counter: got %h want %h", o.rd, exp); else passes++;
    model_commit(29, 1'b0, 8'h00);
  endtask

  task automatic test_we_re();
    obs_t o;
    xact(BASE + 32'h02, 1'b1, 1'b1, 8'h77, o);
    model_commit(2, 1'b1, 8'h77);
    checks++; if (o.ack !== 3'b010) $display("FAIL were_ack: got %b want 010", o.ack); else passes++;
    checks++; if (o.rd !== 8'h00) $display("FAIL were_rd: got %h want 00", o.rd); else passes++;
    checks++; if (o.ctrl2[23:16] !== 8'h77) $display("FAIL were_ctrl2: got %h want 77", o.ctrl2[23:16]); else passes++;
  endtask

  task automatic test_random();
    obs_t       o;
    int         ofs;
    logic       we, re;
    logic [7:0] wd, exp_rd, exp_pulse;
    for (int i = 0; i < 300; i++) begin
      status_in = $urandom;
      ofs = $urandom_range(0, 31);
      we  = 1'($urandom_range(0, 1));
      re  = we ? 1'($urandom_range(0, 1)) : 1'b1;
      wd  = 8'($urandom);
      exp_rd    = we ? 8'h00 : exp_read(ofs);
      exp_pulse = (we && ofs == 31) ? wd : 8'h00;
      xact(BASE + 32'(ofs), we, re, wd, o);
      model_commit(ofs, we, wd);
      checks++; if (o.ack !== 3'b010) $display("FAIL rand_ack[%0d]: ofs %0d got %b want 010", i, ofs, o.ack); else passes++;
      checks++; if (o.rd !== exp_rd) $display("FAIL rand_rd[%0d]: ofs %0d we %b got %h want %h", i, ofs, we, o.rd, exp_rd); else passes++;
      checks++; if (o.pulse2 !== exp_pulse) $display("FAIL rand_pulse[%0d]: ofs %0d got %h want %h", i, ofs, o.pulse2, exp_pulse); else passes++;
      checks++; if (o.ctrl2 !== exp_ctrl()) $display("FAIL rand_ctrl[%0d]: ofs %0d got %h want %h", i, ofs, o.ctrl2, exp_ctrl()); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    obs_t       o;
    logic [7:0] exp;
    int         acks;
    acks = 0;
    @(negedge clk);
    bus.RBCP_ACT  = 1'b1;
    bus.RBCP_ADDR = BASE + 32'h01;
    bus.RBCP_WE   = 1'b1;
    bus.RBCP_WD   = 8'h5A;
    @(negedge clk);
    bus.RBCP_WE = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.RBCP_ACK !== 1'b0 || bus.RBCP_RD !== 8'h00 || pulse_out !== 8'h00)
      $display("FAIL midrst_outputs: ack %b rd %h pulse %h want 0 00 00", bus.RBCP_ACK, bus.RBCP_RD, pulse_out); else passes++;
    checks++; if (ctrl_out !== INIT) $display("FAIL midrst_ctrl: got %h want %h", ctrl_out, INIT); else passes++;
    @(negedge clk);
    rst = 1'b0;
    bus.RBCP_ACT = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.RBCP_ACK === 1'b1) acks++;
    end
    checks++; if (acks !== 0 || ctrl_out !== exp_ctrl()) $display("FAIL midrst_after: acks %0d ctrl %h want 0 %h", acks, ctrl_out, exp_ctrl()); else passes++;
    exp = exp_read(29);
    xact(BASE + 32'h1D, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== exp) $display("FAIL midrst_counter: got %h want %h", o.rd, exp); else passes++;
    model_commit(29, 1'b0, 8'h00);
  endtask

  task automatic test_counter_wrap();
    obs_t       o;
    int         bad_acks;
    int         ofs;
    logic [7:0] wd, exp;
    bad_acks = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      ofs = $urandom_range(0, NC - 1);
      wd  = 8'($urandom);
      xact(BASE + 32'(ofs), 1'b1, 1'b0, wd, o);
      if (o.ack !== 3'b010) bad_acks++;
      model_commit(ofs, 1'b1, wd);
    end
    checks++; if (bad_acks !== 0) $display("FAIL wrap_acks: bad %0d want 0", bad_acks); else passes++;
    checks++; if (ctrl_out !== exp_ctrl()) $display("FAIL wrap_ctrl: got %h want %h", ctrl_out, exp_ctrl()); else passes++;
    xact(BASE + 32'h1D, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h00) $display("FAIL wrap_counter0: got %h want 00", o.rd); else passes++;
    model_commit(29, 1'b0, 8'h00);
    exp = exp_read(29);
    xact(BASE + 32'h1D, 1'b0, 1'b1, 8'h00, o);
    checks++; if (o.rd !== 8'h01 || o.rd !== exp) $display("FAIL wrap_counter1: got %h want 01", o.rd); else passes++;
    model_commit(29, 1'b0, 8'h00);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_write_read_ctrl();
    test_status_version();
    test_pulse();
    test_out_of_window();
    test_strobe_in_access();
    test_abort();
    test_we_re();
    test_random();
    test_reset_mid();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_rbcp_reg_bank
